painter_pen_ctrl: RTL and testbench

Parametrised successor of the painter's pen/cursor unit. It turns debounced direction keys into a clamped cursor position, with auto-repeat on held keys. While draw or erase is active it stamps a square brush of 1..4 pixels onto the VRAM write port, one pixel per cycle. The block sits between the board switches/buttons and the VRAM port A (we/waddr/wdata), in the same clock domain as that port.

---
 rtl/painter_pkg.sv | 24 ++
 rtl/painter_key_repeat.sv | 69 ++++++
 rtl/painter_pen_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_painter_pen_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/painter_pkg.sv
// Shared definitions for the painter pen/cursor unit.
package painter_pkg;

    // Bit positions inside the 4-bit direction vector {up,down,left,right}.
    localparam int DIR_UP = 3;
    localparam int DIR_DN = 2;
    localparam int DIR_LT = 1;
    localparam int DIR_RT = 0;

    // Largest brush edge in pixels and the width needed to hold it.
    localparam int BRUSH_MAX = 4;
    localparam int SW        = $clog2(BRUSH_MAX + 1);

    typedef enum logic {
        IDLE,
        STAMP
    } state_t;

    // True when exactly one key of the direction vector is pressed.
    function automatic logic is_one_hot(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/painter_key_repeat.sv
// Direction key edge detector with auto-repeat: emits a one-cycle move pulse
// when a single key is newly pressed, then repeatedly while it stays held.
module painter_key_repeat
    import painter_pkg::*;
#(
    parameter int REPEAT_DLY  = 25000000,
    parameter int REPEAT_RATE = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dir,
    output logic       move,
    output logic [3:0] move_dir
);

    localparam int CMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DLY_C  = CW'(REPEAT_DLY);
    localparam logic [CW-1:0] RATE_C = CW'(REPEAT_RATE);

    logic [3:0]    dir_q;
    logic [3:0]    dir_prev;
    logic [CW-1:0] cnt;
    logic          repeating;

    logic          hot;
    logic          changed;
    logic [CW-1:0] limit;
    logic [CW-1:0] cnt_inc;

    assign hot     = is_one_hot(dir_q);
    assign changed = (dir_q != dir_prev);
    // The first repeat waits the long delay, later ones the short rate.
    assign limit   = repeating ? RATE_C : DLY_C;
    assign cnt_inc = cnt + 1'b1;

    // Register the keys, detect a fresh single-key press and time repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q     <= '0;
            dir_prev  <= '0;
            cnt       <= '0;
            repeating <= 1'b0;
            move      <= 1'b0;
            move_dir  <= '0;
        end else begin
            dir_q    <= dir;
            dir_prev <= dir_q;
            move     <= 1'b0;
            if (!hot) begin
                cnt       <= '0;
                repeating <= 1'b0;
            end else if (changed) begin
                move      <= 1'b1;
                move_dir  <= dir_q;
                cnt       <= '0;
                repeating <= 1'b0;
            end else if (cnt_inc == limit) begin
                move      <= 1'b1;
                move_dir  <= dir_q;
                cnt       <= '0;
                repeating <= 1'b1;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/painter_pen_ctrl.sv
// Pen/cursor unit: clamped cursor driven by direction keys, and a square
// brush stamped onto the VRAM write port one pixel per cycle.
module painter_pen_ctrl
    import painter_pkg::*;
#(
    parameter int H_PIX       = 200,
    parameter int V_PIX       = 150,
    parameter int AW          = 15,
    parameter int DW          = 12,
    parameter int REPEAT_DLY  = 25000000,
    parameter int REPEAT_RATE = 5000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    dir,
    input  logic [DW-1:0] rgb,
    input  logic          draw,
    input  logic          erase,
    input  logic [1:0]    brush,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic [7:0]    cur_x,
    output logic [7:0]    cur_y,
    output logic          busy
);

    localparam logic [7:0]    X_RST    = 8'(H_PIX / 2 - 1);
    localparam logic [7:0]    Y_RST    = 8'(V_PIX / 2 - 1);
    localparam logic [7:0]    X_MAX    = 8'(H_PIX - 1);
    localparam logic [7:0]    Y_MAX    = 8'(V_PIX - 1);
    localparam logic [AW-1:0] ADDR_RST = AW'((V_PIX / 2 - 1) * H_PIX + (H_PIX / 2 - 1));

    function automatic logic [AW-1:0] pix_addr(input logic [8:0] x, input logic [8:0] y);
        return AW'(y) * AW'(H_PIX) + AW'(x);
    endfunction

    logic          move;
    logic [3:0]    move_dir;
    state_t        state;
    state_t        state_next;
    logic          pend;
    logic [3:0]    pend_dir;
    logic          moved;
    logic          pen_q;
    logic [1:0]    brush_q;
    logic [SW-1:0] size;
    logic [1:0]    dx;
    logic [1:0]    dy;
    logic [DW-1:0] col;
    logic [7:0]    ox;
    logic [7:0]    oy;

    logic          pen;
    logic          block;
    logic          apply;
    logic [3:0]    apply_dir;
    logic          req;
    logic          row_end;
    logic          last_px;
    logic [8:0]    px;
    logic [8:0]    py;
    logic          in_range;

    painter_key_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_RATE(REPEAT_RATE)
    ) u_keys (
        .clk     (clk),
        .rst     (rst),
        .dir     (dir),
        .move    (move),
        .move_dir(move_dir)
    );

    assign pen       = draw | erase;
    // Moves wait while a stamp is selecting or still writing pixels.
    assign block     = (state == STAMP) || busy;
    assign apply     = !block && (pend || move);
    assign apply_dir = pend ? pend_dir : move_dir;
    assign req       = pen && (!pen_q || moved || (brush != brush_q));
    assign row_end   = (SW'(dx) == size - SW'(1));
    assign last_px   = row_end && (SW'(dy) == size - SW'(1));
    assign px        = {1'b0, ox} + 9'(dx);
    assign py        = {1'b0, oy} + 9'(dy);
    assign in_range  = (px <= 9'(H_PIX - 1)) && (py <= 9'(V_PIX - 1));

    // Cursor position with clamping, plus the one-deep pending move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x    <= X_RST;
            cur_y    <= Y_RST;
            moved    <= 1'b0;
            pend     <= 1'b0;
            pend_dir <= '0;
        end else begin
            moved <= apply;
            if (apply) begin
                if (apply_dir[DIR_UP] && cur_y != 8'd0)  cur_y <= cur_y - 8'd1;
                if (apply_dir[DIR_DN] && cur_y != Y_MAX) cur_y <= cur_y + 8'd1;
                if (apply_dir[DIR_LT] && cur_x != 8'd0)  cur_x <= cur_x - 8'd1;
                if (apply_dir[DIR_RT] && cur_x != X_MAX) cur_x <= cur_x + 8'd1;
            end
            if (block) begin
                if (move && !pend) begin
                    pend     <= 1'b1;
                    pend_dir <= move_dir;
                end
            end else begin
                pend <= 1'b0;
            end
        end
    end

    // History of pen and brush used to detect new stamp requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pen_q   <= 1'b0;
            brush_q <= '0;
        end else begin
            pen_q   <= pen;
            brush_q <= brush;
        end
    end

    // Stamp state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Stamp next-state: start on a request, finish after the last offset.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = STAMP;
            STAMP:   if (last_px) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch brush geometry on entry and walk offsets row-major.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size <= SW'(1);
            col  <= '0;
            ox   <= X_RST;
            oy   <= Y_RST;
            dx   <= '0;
            dy   <= '0;
        end else if (state == IDLE) begin
            if (req) begin
                size <= SW'(brush) + SW'(1);
                col  <= erase ? '0 : rgb;
                ox   <= cur_x;
                oy   <= cur_y;
                dx   <= '0;
                dy   <= '0;
            end
        end else if (row_end) begin
            dx <= '0;
            dy <= dy + 2'd1;
        end else begin
            dx <= dx + 2'd1;
        end
    end

    // Registered write port; when idle the address follows the cursor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= ADDR_RST;
            wdata <= '0;
            busy  <= 1'b0;
        end else if (state == STAMP) begin
            we    <= in_range;
            waddr <= pix_addr(px, py);
            wdata <= col;
            busy  <= 1'b1;
        end else begin
            we    <= 1'b0;
            waddr <= pix_addr({1'b0, cur_x}, {1'b0, cur_y});
            wdata <= '0;
            busy  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_painter_pen_ctrl.sv
// Bench for painter_pen_ctrl: directed scenarios followed by random pen,
// brush, colour and key operations checked against a pixel-list model.
module tb_painter_pen_ctrl;

    localparam int H  = 200;
    localparam int V  = 150;
    localparam int AW = 15;
    localparam int DW = 12;
    localparam int W  = AW + DW;

    localparam logic [3:0] K_UP = 4'b1000;
    localparam logic [3:0] K_DN = 4'b0100;
    localparam logic [3:0] K_LT = 4'b0010;
    localparam logic [3:0] K_RT = 4'b0001;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    dir;
    logic [DW-1:0] rgb;
    logic          draw;
    logic          erase;
    logic [1:0]    brush;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [7:0]    cur_x;
    logic [7:0]    cur_y;
    logic          busy;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_busy   = 0;

    // Reference state: cursor, pen inputs and brush as the model sees them.
    int            mx;
    int            my;
    int            m_brush;
    logic          m_draw;
    logic          m_erase;
    logic [DW-1:0] m_rgb;

    painter_pen_ctrl #(
        .H_PIX(H), .V_PIX(V), .AW(AW), .DW(DW),
        .REPEAT_DLY(10), .REPEAT_RATE(4)
    ) dut (
        .clk(clk), .rst(rst), .dir(dir), .rgb(rgb), .draw(draw), .erase(erase),
        .brush(brush), .we(we), .waddr(waddr), .wdata(wdata),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Write monitor: collect every VRAM write and count busy cycles.
    always @(posedge clk) begin
        #1;
        if (we === 1'b1) got_q.push_back({waddr, wdata});
        if (busy === 1'b1) n_busy++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic compare_writes(input string tag);
        logic [W-1:0] g;
        logic [W-1:0] e;
        check({tag, "_nwr"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_wr"}, g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // Every in-canvas pixel of the brush square, row by row.
    task automatic model_stamp();
        int s;
        logic [DW-1:0] c;
        s = m_brush + 1;
        c = m_erase ? '0 : m_rgb;
        for (int yy = 0; yy < s; yy++)
            for (int xx = 0; xx < s; xx++)
                if (mx + xx < H && my + yy < V)
                    exp_q.push_back({AW'((my + yy) * H + mx + xx), c});
    endtask

    task automatic model_move(input logic [3:0] d);
        if (d == K_UP) my = (my > 0) ? my - 1 : 0;
        if (d == K_DN) my = (my < V - 1) ? my + 1 : V - 1;
        if (d == K_LT) mx = (mx > 0) ? mx - 1 : 0;
        if (d == K_RT) mx = (mx < H - 1) ? mx + 1 : H - 1;
    endtask

    task automatic press(input logic [3:0] d);
        dir = d;
        settle(2);
        dir = 4'd0;
        settle(3);
    endtask

    task automatic hold(input logic [3:0] d, input int n);
        dir = d;
        settle(n);
        dir = 4'd0;
        settle(5);
    endtask

    initial begin
        int op;
        int nb;
        logic nd;
        logic ne;
        logic old_pen;
        logic [3:0] d;

        // Reset
        rst = 1'b1; dir = 4'd0; rgb = '0; draw = 1'b0; erase = 1'b0; brush = 2'd0;
        mx = 99; my = 74; m_brush = 0; m_draw = 1'b0; m_erase = 1'b0; m_rgb = '0;
        settle(3);
        rst = 1'b0;
        tick();
        check("rst_cur_x", cur_x, 99);
        check("rst_cur_y", cur_y, 74);
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 14899);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);

        // 1x1 stamp on pen-down
        rgb = 12'hF00; m_rgb = 12'hF00; draw = 1'b1; m_draw = 1'b1;
        tick();
        check("t1_we_early", we, 0);
        tick();
        check("t1_we", we, 1);
        check("t1_waddr", waddr, 14899);
        check("t1_wdata", wdata, 12'hF00);
        check("t1_busy", busy, 1);
        tick();
        check("t1_we_end", we, 0);
        check("t1_busy_end", busy, 0);
        model_stamp();
        compare_writes("t1");

        // Brush change restamps 2x2, then one move right stamps again
        brush = 2'd1; m_brush = 1;
        model_stamp();
        settle(20);
        compare_writes("t2a");
        press(K_RT);
        settle(20);
        exp_q.push_back({15'd14900, 12'hF00});
        exp_q.push_back({15'd14901, 12'hF00});
        exp_q.push_back({15'd15100, 12'hF00});
        exp_q.push_back({15'd15101, 12'hF00});
        compare_writes("t2b");
        check("t2_cur_x", cur_x, 100);

        // Auto-repeat timing and left clamp, pen up
        draw = 1'b0; m_draw = 1'b0;
        hold(K_LT, 500);
        check("t3_x0", cur_x, 0);
        press(K_RT);
        press(K_RT);
        check("t3_x2", cur_x, 2);
        dir = K_LT;
        settle(2);
        check("t3_x_e1", cur_x, 2);
        tick();
        check("t3_x_e2", cur_x, 1);
        settle(9);
        check("t3_x_e11", cur_x, 1);
        tick();
        check("t3_x_e12", cur_x, 0);
        settle(4);
        check("t3_x_e16", cur_x, 0);
        settle(8);
        check("t3_x_e24", cur_x, 0);
        dir = 4'd0;
        settle(5);
        compare_writes("t3");

        // Bottom-right corner: 4x4 erase, only two pixels land on canvas
        hold(K_RT, 1000);
        check("t4_xmax", cur_x, 199);
        press(K_LT);
        hold(K_DN, 400);
        check("t4_ymax", cur_y, 149);
        mx = 198; my = 149;
        n_busy = 0;
        brush = 2'd3; m_brush = 3; rgb = 12'h123; m_rgb = 12'h123;
        draw = 1'b1; erase = 1'b1; m_draw = 1'b1; m_erase = 1'b1;
        model_stamp();
        settle(40);
        check("t4_busy_cycles", n_busy, 16);
        compare_writes("t4");

        // Two presses during a 4x4 stamp: only the first survives
        draw = 1'b0; erase = 1'b0; m_draw = 1'b0; m_erase = 1'b0;
        settle(5);
        repeat (9) press(K_UP);
        check("t5_y140", cur_y, 140);
        my = 140;
        rgb = 12'h0AB; m_rgb = 12'h0AB; draw = 1'b1; m_draw = 1'b1;
        settle(2);
        dir = K_DN; settle(2); dir = 4'd0; settle(3);
        dir = K_DN; settle(2); dir = 4'd0; settle(3);
        check("t5_y_held", cur_y, 140);
        check("t5_busy", busy, 1);
        model_stamp();
        settle(50);
        my = 141;
        model_stamp();
        compare_writes("t5");
        check("t5_y141", cur_y, 141);

        // Reset in the middle of a stamp
        brush = 2'd2; m_brush = 2;
        settle(5);
        check("t6_we_pre", we, 1);
        rst = 1'b1; draw = 1'b0; m_draw = 1'b0;
        #1;
        check("t6_we", we, 0);
        check("t6_busy", busy, 0);
        check("t6_x", cur_x, 99);
        check("t6_y", cur_y, 74);
        settle(2);
        got_q.delete();
        rst = 1'b0;
        mx = 99; my = 74;
        settle(20);
        check("t6_no_writes", got_q.size(), 0);
        got_q.delete();

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    d = 4'd1 << $urandom_range(0, 3);
                    press(d);
                    model_move(d);
                    if (m_draw | m_erase) model_stamp();
                end
                1: begin
                    nb = $urandom_range(0, 3);
                    if (nb != m_brush) begin
                        brush = 2'(nb);
                        m_brush = nb;
                        if (m_draw | m_erase) model_stamp();
                    end
                    tick();
                end
                2: begin
                    nd = 1'($urandom_range(0, 1));
                    ne = 1'($urandom_range(0, 1));
                    old_pen = m_draw | m_erase;
                    draw = nd; erase = ne; m_draw = nd; m_erase = ne;
                    if ((nd | ne) && !old_pen) model_stamp();
                    tick();
                end
                default: begin
                    m_rgb = DW'($urandom_range(0, 4095));
                    rgb = m_rgb;
                    tick();
                end
            endcase
            settle(45);
            compare_writes("rnd");
            check("rnd_x", cur_x, mx);
            check("rnd_y", cur_y, my);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
